// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer for the Sobel gradient datapath.
// Walks the interior pixels of an IMG_W x IMG_H frame, builds each 3x3 window from a
// 1-cycle-latency pixel memory, hands it to the calc stage and writes the results in
// arrival order to the output memory.
// Optional build macro: SOBEL_FRAME_CTRL_PERF_EN adds the busy-cycle counter on cycles_o.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic [71:0]       win_o,
  output logic              win_valid_o,
  input  logic [7:0]        calc_pix_i,
  input  logic              calc_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [31:0]       cycles_o
);

  localparam int unsigned       NumOut   = (IMG_W - 2) * (IMG_H - 2);
  localparam logic [ADDR_W:0]   LpNumOut = (ADDR_W + 1)'(NumOut);
  localparam logic [ADDR_W-1:0] LpLastX  = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LpLastY  = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] LpWidth  = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLast,
    StIssue,
    StDrain,
    StFin
  } state_e;

  state_e r_state, w_state_next;

  // Current window centre and fetch mode
  logic [ADDR_W-1:0] r_x, r_y;
  logic              r_rowstart;
  // Position of the next read inside the 3x3 neighbourhood (column L/M/R, row top/mid/bot)
  logic [1:0]        r_col_off, r_row_off;

  // Read-data capture pipeline: slot of the read issued last cycle
  logic              r_cap_en;
  logic [1:0]        r_cap_col, r_cap_row;
  logic [3:0]        w_cap_idx;

  logic [8:0][7:0]   r_win;

  // Result write path
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_wr_accept;
  logic [ADDR_W:0]   w_wr_cnt;

  logic              w_start;
  logic              w_last_rd;
  logic              w_shift;
  logic              w_row_wrap;
  logic              w_frame_end;
  logic [ADDR_W-1:0] w_rd_row, w_rd_col, w_rd_addr;

  assign w_start     = (r_state == StIdle) && start_i;
  assign w_last_rd   = (r_col_off == 2'd2) && (r_row_off == 2'd2);
  assign w_row_wrap  = (r_x == LpLastX);
  assign w_frame_end = w_row_wrap && (r_y == LpLastY);

  // In shift mode only column R is fetched; the first fetch cycle slides L<=M, M<=R.
  assign w_shift = (r_state == StFetch) && !r_rowstart &&
                   (r_col_off == 2'd2) && (r_row_off == 2'd0);

  // Neighbourhood coordinates relative to the centre (x, y); never leave the frame.
  assign w_rd_row  = r_y - ADDR_W'(1) + {{(ADDR_W-2){1'b0}}, r_row_off};
  assign w_rd_col  = r_x - ADDR_W'(1) + {{(ADDR_W-2){1'b0}}, r_col_off};
  assign w_rd_addr = w_rd_row * LpWidth + w_rd_col;

  assign w_cap_idx = ({2'b00, r_cap_row} * 4'd3) + {2'b00, r_cap_col};

  // Results are only taken while a frame is in progress.
  assign w_wr_accept = calc_valid_i && (r_state != StIdle);
  // Writes done so far, counting one still on the output port this cycle.
  assign w_wr_cnt    = {1'b0, r_wr_addr} + {{ADDR_W{1'b0}}, r_wr_en};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and strobe outputs
  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    rd_en_o      = 1'b0;
    rd_addr_o    = '0;
    win_valid_o  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        busy_o    = 1'b1;
        rd_en_o   = 1'b1;
        rd_addr_o = w_rd_addr;
        if (w_last_rd) begin
          w_state_next = StLast;
        end
      end
      StLast: begin
        busy_o       = 1'b1;
        w_state_next = StIssue;
      end
      StIssue: begin
        busy_o       = 1'b1;
        win_valid_o  = 1'b1;
        w_state_next = w_frame_end ? StDrain : StFetch;
      end
      StDrain: begin
        busy_o = 1'b1;
        if (w_wr_cnt >= LpNumOut) begin
          w_state_next = StFin;
        end
      end
      StFin: begin
        done_o       = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Window centre and intra-window read position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_rowstart <= 1'b0;
      r_col_off  <= 2'd0;
      r_row_off  <= 2'd0;
    end else begin
      if (w_start) begin
        r_x        <= ADDR_W'(1);
        r_y        <= ADDR_W'(1);
        r_rowstart <= 1'b1;
        r_col_off  <= 2'd0;
        r_row_off  <= 2'd0;
      end else if (r_state == StFetch) begin
        // Column-major walk: rows top..bottom, then next column.
        if (r_row_off == 2'd2) begin
          r_row_off <= 2'd0;
          r_col_off <= r_col_off + 2'd1;
        end else begin
          r_row_off <= r_row_off + 2'd1;
        end
      end else if ((r_state == StIssue) && !w_frame_end) begin
        r_row_off <= 2'd0;
        if (w_row_wrap) begin
          r_x        <= ADDR_W'(1);
          r_y        <= r_y + ADDR_W'(1);
          r_rowstart <= 1'b1;
          r_col_off  <= 2'd0;
        end else begin
          r_x        <= r_x + ADDR_W'(1);
          r_rowstart <= 1'b0;
          r_col_off  <= 2'd2;
        end
      end
    end
  end

  // Window shift and capture of read data one cycle after each read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_en  <= 1'b0;
      r_cap_col <= 2'd0;
      r_cap_row <= 2'd0;
      r_win     <= '0;
    end else begin
      r_cap_en  <= rd_en_o;
      r_cap_col <= r_col_off;
      r_cap_row <= r_row_off;
      if (w_shift) begin
        for (int r = 0; r < 3; r++) begin
          r_win[3*r]     <= r_win[3*r + 1];
          r_win[3*r + 1] <= r_win[3*r + 2];
        end
      end
      if (r_cap_en) begin
        r_win[w_cap_idx] <= rd_data_i;
      end
    end
  end

  // Register calc results into the output memory port, addresses in arrival order
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'd0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en <= w_wr_accept;
      if (w_wr_accept) begin
        r_wr_data <= calc_pix_i;
      end
      if (w_start || (r_state == StFin)) begin
        r_wr_addr <= '0;
      end else if (r_wr_en) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
      end
    end
  end

  assign win_o     = r_win;
  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;

`ifdef SOBEL_FRAME_CTRL_PERF_EN
  logic [31:0] r_cycles;

  // Busy-cycle counter: cleared on start, holds after the frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= 32'd0;
    end else if (w_start) begin
      r_cycles <= 32'd0;
    end else if (busy_o) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles_o = r_cycles;
`else
  assign cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a 4x4 frame: pixel memory and Sobel calc models attached,
// expected per-cycle behaviour derived from the frame walk rules, plus literal expectations.
module tb_sobel_frame_ctrl;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int AW     = 4;
  localparam int MAXOFF = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, rd_en_o, win_valid_o, wr_en_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [7:0]    rd_data_i = 8'd0;
  logic [71:0]   win_o;
  logic [7:0]    calc_pix_i, wr_data_o;
  logic          calc_valid_i;
  logic [31:0]   cycles_o;

  sobel_frame_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .win_o       (win_o),
    .win_valid_o (win_valid_o),
    .calc_pix_i  (calc_pix_i),
    .calc_valid_i(calc_valid_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .cycles_o    (cycles_o)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory, one-cycle read latency
  logic [7:0] mem [W*H];
  always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  function automatic logic [7:0] sobel(input logic [71:0] w);
    int d[9];
    int gx, gy, m;
    for (int k = 0; k < 9; k++) d[k] = int'(w[8*k +: 8]);
    gx = (d[2] + 2*d[5] + d[8]) - (d[0] + 2*d[3] + d[6]);
    gy = (d[6] + 2*d[7] + d[8]) - (d[0] + 2*d[1] + d[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  // Calc stage: fixed latency lat >= 1 cycles from win_valid_o to calc_valid_i
  int         lat = 1;
  logic       cv [16];
  logic [7:0] cp [16];
  always @(posedge clk) begin
    for (int i = 0; i < 15; i++) begin
      cv[i] <= cv[i+1];
      cp[i] <= cp[i+1];
    end
    cv[15] <= 1'b0;
    cp[15] <= 8'd0;
    if (rst) begin
      for (int i = 0; i < 16; i++) cv[i] <= 1'b0;
    end else if (win_valid_o) begin
      cv[lat-1] <= 1'b1;
      cp[lat-1] <= sobel(win_o);
    end
  end
  assign calc_valid_i = cv[0];
  assign calc_pix_i   = cp[0];

  // Expected behaviour per cycle offset from the start cycle
  logic          e_rd_en [MAXOFF];
  logic [AW-1:0] e_rd_addr [MAXOFF];
  logic          e_wv [MAXOFF];
  logic [71:0]   e_win [MAXOFF];
  logic          e_wr [MAXOFF];
  logic [AW-1:0] e_wr_addr [MAXOFF];
  logic [7:0]    e_wr_data [MAXOFF];
  logic          e_busy [MAXOFF];
  logic          e_done [MAXOFF];
  int            done_off;

  // What the DUT actually did, per offset
  logic [AW-1:0] lg_rd_addr [MAXOFF];
  logic          lg_wv [MAXOFF];
  logic [71:0]   lg_win [MAXOFF];
  logic          lg_wr [MAXOFF];
  logic [7:0]    lg_wr_data [MAXOFF];
  logic [AW-1:0] lg_wr_addr [MAXOFF];
  logic          lg_done [MAXOFF];

  int   n_chk = 0;
  int   n_err = 0;
  logic m_active = 1'b0;
  int   m_base = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Frame walk: raster order of interior pixels; 9 reads at row start, else 3; LAST; ISSUE.
  task automatic build_model(input int l);
    int off, k, t_last;
    logic [71:0] w;
    for (int o = 0; o < MAXOFF; o++) begin
      e_rd_en[o] = 0; e_rd_addr[o] = '0; e_wv[o] = 0; e_win[o] = '0;
      e_wr[o] = 0; e_wr_addr[o] = '0; e_wr_data[o] = '0; e_busy[o] = 0; e_done[o] = 0;
    end
    off = 1; k = 0; t_last = 0;
    for (int y = 1; y <= H-2; y++) begin
      for (int x = 1; x <= W-2; x++) begin
        if (x == 1) begin
          for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
              e_rd_en[off] = 1; e_rd_addr[off] = AW'((y-1+r)*W + x-1+c); off++;
            end
          end
        end else begin
          for (int r = 0; r < 3; r++) begin
            e_rd_en[off] = 1; e_rd_addr[off] = AW'((y-1+r)*W + x+1); off++;
          end
        end
        off++;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) w[8*(r*3+c) +: 8] = mem[(y-1+r)*W + x-1+c];
        e_wv[off] = 1; e_win[off] = w;
        e_wr[off+l+1] = 1; e_wr_addr[off+l+1] = AW'(k); e_wr_data[off+l+1] = sobel(w);
        t_last = off; off++; k++;
      end
    end
    done_off = t_last + l + 2;
    for (int o = 1; o < done_off; o++) e_busy[o] = 1;
    e_done[done_off] = 1;
  endtask

  task automatic compare_loop();
    int o;
    forever begin
      @(negedge clk);
      if (m_active) begin
        o = cyc - m_base;
        if (o >= 0 && o < MAXOFF) begin
          lg_rd_addr[o] = rd_addr_o; lg_wv[o] = win_valid_o; lg_win[o] = win_o;
          lg_wr[o] = wr_en_o; lg_wr_data[o] = wr_data_o; lg_wr_addr[o] = wr_addr_o;
          lg_done[o] = done_o;
          chk("busy_o", 72'(busy_o), 72'(e_busy[o]));
          chk("done_o", 72'(done_o), 72'(e_done[o]));
          chk("rd_en_o", 72'(rd_en_o), 72'(e_rd_en[o]));
          if (e_rd_en[o]) chk("rd_addr_o", 72'(rd_addr_o), 72'(e_rd_addr[o]));
          chk("win_valid_o", 72'(win_valid_o), 72'(e_wv[o]));
          if (e_wv[o]) chk("win_o", win_o, e_win[o]);
          chk("wr_en_o", 72'(wr_en_o), 72'(e_wr[o]));
          if (e_wr[o]) begin
            chk("wr_addr_o", 72'(wr_addr_o), 72'(e_wr_addr[o]));
            chk("wr_data_o", 72'(wr_data_o), 72'(e_wr_data[o]));
          end
`ifdef SOBEL_FRAME_CTRL_PERF_EN
          if (o >= 1)
            chk("cycles_o", 72'(cycles_o), 72'((o-1 < done_off-1) ? o-1 : done_off-1));
`else
          chk("cycles_o", 72'(cycles_o), 72'(0));
`endif
        end
      end
    end
  endtask

  task automatic run_frame(input int l, input int p1, input int p2);
    lat = l;
    build_model(l);
    for (int o = 0; o < MAXOFF; o++) begin
      lg_rd_addr[o] = '0; lg_wv[o] = 0; lg_win[o] = '0; lg_wr[o] = 0;
      lg_wr_data[o] = '0; lg_wr_addr[o] = '0; lg_done[o] = 0;
    end
    @(posedge clk); #1;
    start_i = 1'b1; m_base = cyc; m_active = 1'b1;
    for (int o = 1; o < MAXOFF; o++) begin
      @(posedge clk); #1;
      start_i = (o == p1) || (o == p2);
    end
    @(posedge clk); #1;
    start_i = 1'b0; m_active = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       mem[y*W+x] = 8'd100;
          1:       mem[y*W+x] = (x >= 2) ? 8'd200 : 8'd0;
          default: mem[y*W+x] = 8'(y*W + x);
        endcase
  endtask

  initial begin
    int n;
    int seq_a[9];
    int seq_b[3];
    seq_a = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
    seq_b = '{3, 7, 11};
    fork
      compare_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy_o", 72'(busy_o), 72'(0));
    chk("rst done_o", 72'(done_o), 72'(0));
    chk("rst rd_en_o", 72'(rd_en_o), 72'(0));
    chk("rst win_o", win_o, 72'(0));
    chk("rst win_valid_o", 72'(win_valid_o), 72'(0));
    chk("rst wr_en_o", 72'(wr_en_o), 72'(0));
    chk("rst wr_addr_o", 72'(wr_addr_o), 72'(0));
    chk("rst cycles_o", 72'(cycles_o), 72'(0));

    // Flat frame: all gradients zero, one done pulse
    fill(0);
    run_frame(1, 0, 0);
    chk("flat done_off", 72'(done_off), 72'(35));
    chk("flat wr0 data", 72'(lg_wr_data[13]), 72'(0));
    chk("flat wr3 data", 72'(lg_wr_data[34]), 72'(0));
    chk("flat wr3 en", 72'(lg_wr[34]), 72'(1));
    n = 0;
    for (int o = 0; o < MAXOFF; o++) if (lg_done[o]) n++;
    chk("flat done count", 72'(n), 72'(1));

    // Vertical edge: saturated outputs, known first window
    fill(1);
    run_frame(1, 0, 0);
    chk("edge model win", e_win[11], 72'hC80000C80000C80000);
    chk("edge first win", lg_win[11], 72'hC80000C80000C80000);
    chk("edge wr0 data", 72'(lg_wr_data[13]), 72'(255));
    chk("edge wr3 data", 72'(lg_wr_data[34]), 72'(255));

    // Ramp frame: read order and window timing; start pulses while busy and in FIN ignored
    fill(2);
    build_model(2);
    for (int i = 0; i < 9; i++) chk("model rd seq", 72'(e_rd_addr[1+i]), 72'(seq_a[i]));
    run_frame(2, 20, 36);
    for (int i = 0; i < 9; i++) chk("ramp rd seq a", 72'(lg_rd_addr[1+i]), 72'(seq_a[i]));
    for (int i = 0; i < 3; i++) chk("ramp rd seq b", 72'(lg_rd_addr[12+i]), 72'(seq_b[i]));
    chk("ramp wv 11", 72'(lg_wv[11]), 72'(1));
    chk("ramp wv 16", 72'(lg_wv[16]), 72'(1));

    // Slow calc: done only after the fourth write
    run_frame(7, 0, 0);
    chk("slow done_off", 72'(done_off), 72'(41));
    chk("slow last wr", 72'(lg_wr[40]), 72'(1));
    chk("slow last addr", 72'(lg_wr_addr[40]), 72'(3));
    chk("slow done", 72'(lg_done[41]), 72'(1));
    n = 0;
    for (int o = 0; o < MAXOFF; o++) if (lg_wr[o]) n++;
    chk("slow wr count", 72'(n), 72'(4));

    // Reset during the second fetch aborts the frame
    lat = 1;
    @(posedge clk); #1;
    start_i = 1'b1; m_base = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort pre rd_en", 72'(rd_en_o), 72'(1));
    chk("abort pre rd_addr", 72'(rd_addr_o), 72'(3));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort rd_en_o", 72'(rd_en_o), 72'(0));
    chk("abort win_valid_o", 72'(win_valid_o), 72'(0));
    chk("abort wr_en_o", 72'(wr_en_o), 72'(0));
    chk("abort busy_o", 72'(busy_o), 72'(0));
    repeat (4) @(negedge clk);
    chk("abort idle rd_en", 72'(rd_en_o), 72'(0));
    chk("abort idle wr_en", 72'(wr_en_o), 72'(0));
    run_frame(1, 0, 0);
    chk("restart rd addr", 72'(lg_rd_addr[1]), 72'(0));
    chk("restart wr addr", 72'(lg_wr_addr[13]), 72'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err + 1,
             n_chk + 1);
    $fatal(1, "time limit");
  end

endmodule
